// File: rtl/pipelined_shift_unit.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// pipelined_shift_unit
// Purpose: SLL/SRL/SRA/ROL/ROR on a DATA_W-bit operand, spread over NUM_STAGES
//          register stages, with a valid/ready handshake, full backpressure and
//          a sideband tag that travels unchanged with each op.
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   flush            synchronous clear of every stage valid
//   in_valid/ready   input handshake; in_ready = advance & ~flush
//   in_data          operand
//   in_amount        shift/rotate amount (modulo DATA_W by width)
//   in_op            000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, else pass
//   in_tag           sideband returned with the result
//   out_valid/ready  output handshake
//   out_data         result
//   out_tag          tag of the op that produced out_data
// ----------------------------------------------------------------------------
module pipelined_shift_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned TAG_W      = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [$clog2(DATA_W)-1:0] in_amount,
  input  logic [2:0]                in_op,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int unsigned AMT_W = $clog2(DATA_W);
  localparam int unsigned LAST  = NUM_STAGES - 1;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  // First barrel level handled by stage s; stage s covers [lo(s), lo(s+1)).
  function automatic int lvl_lo(input int s);
    lvl_lo = int'((s * AMT_W) / NUM_STAGES);
  endfunction

  // One barrel level: move d by k positions according to op.
  function automatic logic [DATA_W-1:0] f_level(
    input logic [DATA_W-1:0] d,
    input logic [2:0]        op,
    input logic              sgn,
    input int unsigned       k
  );
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] fill;
    res  = d;
    fill = sgn ? ~({DATA_W{1'b1}} >> k) : '0;
    case (op)
      OP_SLL:  res = d << k;
      OP_SRL:  res = d >> k;
      OP_SRA:  res = (d >> k) | fill;
      OP_ROL:  res = (d << k) | (d >> (DATA_W - k));
      OP_ROR:  res = (d >> k) | (d << (DATA_W - k));
      default: res = d;
    endcase
    f_level = res;
  endfunction

  // Stage registers
  logic [NUM_STAGES-1:0] r_valid;
  logic [DATA_W-1:0]     r_data [NUM_STAGES];
  logic [TAG_W-1:0]      r_tag  [NUM_STAGES];
  logic [2:0]            r_op   [NUM_STAGES];
  logic [AMT_W-1:0]      r_amt  [NUM_STAGES];
  logic                  r_sign [NUM_STAGES];

  // Per-stage sources (stage 0 reads the input port) and next values
  logic [DATA_W-1:0]     w_src_data [NUM_STAGES];
  logic [TAG_W-1:0]      w_src_tag  [NUM_STAGES];
  logic [2:0]            w_src_op   [NUM_STAGES];
  logic [AMT_W-1:0]      w_src_amt  [NUM_STAGES];
  logic                  w_src_sign [NUM_STAGES];
  logic [DATA_W-1:0]     w_nxt_data [NUM_STAGES];
  logic                  w_adv;

  // Global advance: the whole pipe moves unless the output is held.
  assign w_adv     = out_ready | ~r_valid[LAST];
  assign in_ready  = w_adv & ~flush;

  assign out_valid = r_valid[LAST];
  assign out_data  = r_data[LAST];
  assign out_tag   = r_tag[LAST];

  // Source selection for every stage
  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_src_data[s] = '0;
      w_src_tag[s]  = '0;
      w_src_op[s]   = '0;
      w_src_amt[s]  = '0;
      w_src_sign[s] = 1'b0;
    end
    w_src_data[0] = in_data;
    w_src_tag[0]  = in_tag;
    w_src_op[0]   = in_op;
    w_src_amt[0]  = in_amount;
    // SRA fill bit is frozen at accept so later stages need not re-derive it.
    w_src_sign[0] = in_data[DATA_W-1];
    for (int s = 1; s < NUM_STAGES; s++) begin
      w_src_data[s] = r_data[s-1];
      w_src_tag[s]  = r_tag[s-1];
      w_src_op[s]   = r_op[s-1];
      w_src_amt[s]  = r_amt[s-1];
      w_src_sign[s] = r_sign[s-1];
    end
  end

  // Barrel levels owned by each stage
  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_nxt_data[s] = w_src_data[s];
      for (int j = 0; j < AMT_W; j++) begin
        if ((j >= lvl_lo(s)) && (j < lvl_lo(s + 1)) && w_src_amt[s][j]) begin
          w_nxt_data[s] = f_level(w_nxt_data[s], w_src_op[s], w_src_sign[s],
                                  32'(1) << j);
        end
      end
    end
  end

  // Pipeline registers: reset > flush > advance; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_data[s] <= '0;
        r_tag[s]  <= '0;
        r_op[s]   <= '0;
        r_amt[s]  <= '0;
        r_sign[s] <= 1'b0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      for (int s = 1; s < NUM_STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
      end
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_data[s] <= w_nxt_data[s];
        r_tag[s]  <= w_src_tag[s];
        r_op[s]   <= w_src_op[s];
        r_amt[s]  <= w_src_amt[s];
        r_sign[s] <= w_src_sign[s];
      end
    end
  end

endmodule
